// File: rtl/r200_pkg.sv
// Shared types and constants for the r200 instruction-fetch stage.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package r200_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0: what decode sees whenever fetch has nothing to offer.
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] instrn;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/r200_fetch_queue.sv
// Fetch queue: synchronous FIFO of fetch entries with a single-cycle flush.
// Latency: a pushed entry is visible at the head on the next clock; the head is read from flops.
// Backpressure: a push while full is taken only together with a pop; flush beats push and pop.
module r200_fetch_queue
    import r200_pkg::*;
#(
    parameter int FQ_DEPTH = 2,
    localparam int AW = $clog2(FQ_DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  fetch_entry_t  i_push_dat,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count,
    output fetch_entry_t  o_head
);

    fetch_entry_t  r_mem [FQ_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(FQ_DEPTH));
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A full queue can still accept a word when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointer and occupancy bookkeeping; a flush empties the queue outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Entry storage; slots written during a flush are unreachable once the pointers reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FQ_DEPTH; i++) r_mem[i] <= '0;
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

endmodule

// File: rtl/r200_fetch_unit.sv
// Instruction fetch: owns the PC, requests imem over req/gnt/rvalid, queues words, hands {instrn,pc,pcp4} to decode.
// Latency: redirect N -> req N+1 -> rvalid N+2 -> if_valid N+3 with a 1-cycle memory and immediate grant.
// Backpressure: if_ready low fills the queue, then requests are withheld; nothing is dropped. R200_FETCH_PERF_EN adds perf counters.
module r200_fetch_unit
    import r200_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instrn,
    output logic [31:0] if_pc,
    output logic [31:0] if_pcp4
`ifdef R200_FETCH_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_redirects
`endif
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    logic [31:0]   r_pc;
    logic [31:0]   r_req_pc;
    logic [31:0]   r_last_pc;
    logic          r_outstanding;
    logic          r_drop;
    logic          r_run;

    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_dat;
    logic          w_push;
    logic          w_pop;
    logic          w_grant;
    logic          w_room;
    logic          w_unused;

    // Only the word-aligned part of a redirect target matters.
    assign w_unused = &{1'b0, redirect_pc[1:0]};

    // Queue slots already in use plus the one reserved by an in-flight request.
    assign w_room = (w_count + CW'(r_outstanding)) < CW'(FQ_DEPTH);

    // r_run keeps the request low while in reset and on the release edge.
    // rvalid frees the single in-flight slot, so a new request may go out the same cycle.
    assign imem_req  = r_run && !redirect_valid && w_room && (!r_outstanding || imem_rvalid);
    assign imem_addr = r_pc;
    assign w_grant   = imem_req && imem_gnt;

    // A response is kept only if it answers a live request and no redirect is flushing.
    assign w_push            = imem_rvalid && r_outstanding && !r_drop && !redirect_valid;
    assign w_push_dat.instrn = imem_rdata;
    assign w_push_dat.pc     = r_req_pc;
    assign w_pop             = if_valid && if_ready;

    r200_fetch_queue #(
        .FQ_DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .i_flush    (redirect_valid),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count),
        .o_head     (w_head)
    );

    // PC, in-flight request tracking and stale-response suppression.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= {RESET_PC[31:2], 2'b00};
            r_req_pc      <= {RESET_PC[31:2], 2'b00};
            r_outstanding <= 1'b0;
            r_drop        <= 1'b0;
            r_run         <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (redirect_valid) begin
                r_pc <= {redirect_pc[31:2], 2'b00};
            end else if (w_grant) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_grant) begin
                r_req_pc      <= r_pc;
                r_outstanding <= 1'b1;
            end else if (imem_rvalid) begin
                r_outstanding <= 1'b0;
            end
            // The response still owed to a pre-redirect request must be thrown away.
            if (imem_rvalid && r_outstanding) begin
                r_drop <= 1'b0;
            end else if (redirect_valid && r_outstanding) begin
                r_drop <= 1'b1;
            end
        end
    end

    // Remember the last presented address so if_pc holds while the queue is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_pc <= RESET_PC;
        end else if (!w_empty) begin
            r_last_pc <= w_head.pc;
        end
    end

    assign if_valid  = !w_empty;
    assign if_instrn = if_valid ? w_head.instrn : NOP_INSTR;
    assign if_pc     = if_valid ? w_head.pc : r_last_pc;
    assign if_pcp4   = if_pc + 32'd4;

`ifdef R200_FETCH_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_redir;

    // Saturating counts of decode stalls and redirect cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_stall <= '0;
            r_perf_redir <= '0;
        end else begin
            if (if_valid && !if_ready && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
            if (redirect_valid && (r_perf_redir != '1))        r_perf_redir <= r_perf_redir + 32'd1;
        end
    end

    assign perf_stall_cycles = r_perf_stall;
    assign perf_redirects    = r_perf_redir;
`endif

endmodule

// File: tb/tb_r200_fetch_unit.sv
`timescale 1ns/1ps
module tb_r200_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] RPC2  = 32'hFFFF_FFFC;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instrn;
    logic [31:0] if_pc;
    logic [31:0] if_pcp4;

    logic        req2;
    logic [31:0] addr2;
    logic        rvalid2;
    logic [31:0] rdata2;
    logic        valid2;
    logic [31:0] instrn2;
    logic [31:0] pc2;
    logic [31:0] pcp42;

`ifdef R200_FETCH_PERF_EN
    logic [31:0] perf_stall_cycles, perf_redirects, perf_stall2, perf_redir2;
`endif

    r200_fetch_unit #(.RESET_PC(RPC), .FQ_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_instrn(if_instrn), .if_pc(if_pc), .if_pcp4(if_pcp4)
`ifdef R200_FETCH_PERF_EN
        , .perf_stall_cycles(perf_stall_cycles), .perf_redirects(perf_redirects)
`endif
    );

    // Second instance starting at the top of the address space, fed by an always-granting 1-cycle memory.
    r200_fetch_unit #(.RESET_PC(RPC2), .FQ_DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .imem_req(req2), .imem_addr(addr2), .imem_gnt(1'b1),
        .imem_rvalid(rvalid2), .imem_rdata(rdata2),
        .if_valid(valid2), .if_ready(1'b1),
        .if_instrn(instrn2), .if_pc(pc2), .if_pcp4(pcp42)
`ifdef R200_FETCH_PERF_EN
        , .perf_stall_cycles(perf_stall2), .perf_redirects(perf_redir2)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Instruction memory contents as seen by both instances.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0010_0093;
        if (a == 32'h4) return 32'h0020_0113;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
    endfunction

    typedef struct {
        logic [31:0] instrn;
        logic [31:0] pc;
    } exp_ent_t;

    // Reference model: instructions decode should see, in order, plus the next address fetch must ask for.
    exp_ent_t    sb[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] m_last_pc;

    // Memory model: at most one request pending; stale = answer owed to a pre-redirect request,
    // orphan = answer owed to a request issued before a reset.
    bit          pend, pend_stale, orphan;
    int          pend_cnt;
    logic [31:0] pend_addr;
    bit          pend2;
    logic [31:0] pend2_addr;

    int          p_gnt, p_ready, p_redir, lat_min, lat_max;
    int          force_mode;
    logic [31:0] force_pc;
    bit          forced_now;
    int          phase, cyc, first_valid_cyc;
    int          n2_grants;
    bit          seen2;
    bit          t3_armed, t3_addr_done, t3_pc_done;
    bit          t4_next, t4_done;
    bit          t6_armed;

    task automatic model_reset();
        sb.delete();
        m_fetch_pc = RPC;
        m_last_pc  = RPC;
    endtask

    task automatic eval_cycle();
        bit rv, outv, exp_req;
        rv   = imem_rvalid;
        outv = pend && !orphan;

        if (t4_next) begin
            check_eq("t4_flushed_valid", if_valid, 1'b0);
            t4_next = 0;
            t4_done = 1;
        end

        exp_req = !redirect_valid && ((sb.size() + int'(outv)) < DEPTH) && (!outv || rv);
        check_eq("imem_req", imem_req, exp_req);
        if (imem_req) check_eq("imem_addr", imem_addr, m_fetch_pc);

        check_eq("if_valid", if_valid, sb.size() != 0);
        if (sb.size() != 0) begin
            check_eq("if_instrn", if_instrn, sb[0].instrn);
            check_eq("if_pc", if_pc, sb[0].pc);
            check_eq("if_pcp4", if_pcp4, sb[0].pc + 32'd4);
            m_last_pc = sb[0].pc;
        end else begin
            check_eq("if_instrn_idle", if_instrn, NOP);
            check_eq("if_pc_idle", if_pc, m_last_pc);
            check_eq("if_pcp4_idle", if_pcp4, m_last_pc + 32'd4);
        end

        if (phase == 1) begin
            if (if_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (cyc == 1) begin
                check_eq("t1_req_c1", imem_req, 1'b1);
                check_eq("t1_addr_c1", imem_addr, 32'h0);
            end
            if (cyc == 3) begin
                check_eq("t1_pc_c3", if_pc, 32'h0);
                check_eq("t1_pcp4_c3", if_pcp4, 32'h4);
                check_eq("t1_instr_c3", if_instrn, 32'h0010_0093);
            end
            if (cyc == 4) begin
                check_eq("t1_pc_c4", if_pc, 32'h4);
                check_eq("t1_instr_c4", if_instrn, 32'h0020_0113);
            end
            if (req2) begin
                n2_grants++;
                if (n2_grants == 1) check_eq("t5_addr_first", addr2, RPC2);
                if (n2_grants == 2) check_eq("t5_addr_wrap", addr2, 32'h0);
            end
            if (valid2 && !seen2) begin
                seen2 = 1;
                check_eq("t5_pc", pc2, RPC2);
                check_eq("t5_pcp4", pcp42, 32'h0);
                check_eq("t5_instr", instrn2, mem_word(RPC2));
            end
        end
        pend2      = req2;
        pend2_addr = addr2;

        if (t3_armed && !t3_addr_done && imem_req && imem_gnt) begin
            check_eq("t3_next_addr", imem_addr, 32'h0000_0100);
            t3_addr_done = 1;
        end
        if (t3_armed && !t3_pc_done && if_valid) begin
            check_eq("t3_first_pc", if_pc, 32'h0000_0100);
            t3_pc_done = 1;
        end
        if (t6_armed && imem_req && imem_gnt) begin
            check_eq("t6_restart_addr", imem_addr, RPC);
            t6_armed = 0;
        end
        if (forced_now && phase == 4) check_eq("t4_req_low", imem_req, 1'b0);

        // Apply this cycle's events to the model.
        if (redirect_valid) begin
            sb.delete();
            m_fetch_pc = {redirect_pc[31:2], 2'b00};
        end else if (if_valid && if_ready && sb.size() != 0) begin
            void'(sb.pop_front());
        end
        if (rv) begin
            if (outv && !pend_stale && !redirect_valid)
                sb.push_back('{instrn: mem_word(pend_addr), pc: pend_addr});
            pend = 0; pend_stale = 0; orphan = 0;
        end else if (pend) begin
            pend_cnt--;
            if (redirect_valid) pend_stale = 1;
        end
        if (imem_req && imem_gnt) begin
            pend       = 1;
            pend_stale = 0;
            orphan     = 0;
            pend_addr  = imem_addr;
            pend_cnt   = $urandom_range(lat_max - 1, lat_min - 1);
            m_fetch_pc = m_fetch_pc + 32'd4;
        end

        if (forced_now && phase == 3) t3_armed = 1;
        if (forced_now && phase == 4) t4_next = 1;
    endtask

    task automatic step();
        bit rv;
        @(posedge clk);
        #1;
        cyc++;
        rv             = pend && (pend_cnt == 0);
        imem_rvalid    = rv;
        imem_rdata     = rv ? mem_word(pend_addr) : $urandom();
        imem_gnt       = !orphan && ($urandom_range(0, 99) < p_gnt);
        if_ready       = ($urandom_range(0, 99) < p_ready);
        redirect_valid = ($urandom_range(0, 99) < p_redir);
        redirect_pc    = $urandom();
        forced_now     = 0;
        if (force_mode == 1 && pend && !orphan && !rv && pend_cnt == 2) begin
            redirect_valid = 1; redirect_pc = force_pc; forced_now = 1; force_mode = 0;
        end
        if (force_mode == 2 && rv && !orphan && sb.size() != 0) begin
            redirect_valid = 1; if_ready = 1; redirect_pc = force_pc; forced_now = 1; force_mode = 0;
        end
        rvalid2 = pend2;
        rdata2  = mem_word(pend2_addr);
        @(negedge clk);
        eval_cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0; redirect_valid = 0; redirect_pc = 0; imem_gnt = 0;
        imem_rvalid = 0; imem_rdata = 0; if_ready = 0; rvalid2 = 0; rdata2 = 0;
        pend = 0; pend_stale = 0; orphan = 0; pend_cnt = 0; pend_addr = 0;
        pend2 = 0; pend2_addr = 0; force_mode = 0; force_pc = 0; forced_now = 0;
        first_valid_cyc = -1; n2_grants = 0; seen2 = 0;
        t3_armed = 0; t3_addr_done = 0; t3_pc_done = 0; t4_next = 0; t4_done = 0; t6_armed = 0;
        model_reset();

        repeat (2) @(negedge clk);
        check_eq("rst_imem_req", imem_req, 1'b0);
        check_eq("rst_if_valid", if_valid, 1'b0);
        check_eq("rst_if_instrn", if_instrn, NOP);
        check_eq("rst_if_pc", if_pc, RPC);
        check_eq("rst_if_pcp4", if_pcp4, RPC + 32'd4);
        check_eq("rst_wrap_pcp4", pcp42, 32'h0);
        rst_n = 1'b1;
        cyc = 0;

        // Straight-line fetch with a 1-cycle memory.
        phase = 1; p_gnt = 100; p_ready = 100; p_redir = 0; lat_min = 1; lat_max = 1;
        repeat (10) step();
        check_eq("t1_first_valid_cyc", first_valid_cyc, 3);
        check_eq("t5_seen", {31'b0, seen2}, 1);

        // Decode stall fills the queue; release must lose and duplicate nothing.
        phase = 2; p_ready = 0;
        repeat (6) step();
        check_eq("t2_full_valid", if_valid, 1'b1);
        check_eq("t2_full_req", imem_req, 1'b0);
        p_ready = 100;
        repeat (10) step();

        // Redirect while a 3-cycle request is in flight.
        phase = 3; lat_min = 3; lat_max = 3; force_mode = 1; force_pc = 32'h0000_0103;
        n = 0;
        while (!(t3_addr_done && t3_pc_done) && n < 40) begin step(); n++; end
        check_eq("t3_done", {31'b0, t3_addr_done && t3_pc_done}, 1);
        force_mode = 0;

        // Redirect colliding with rvalid and a pop.
        phase = 4; lat_min = 1; lat_max = 1; p_ready = 50; force_mode = 2; force_pc = 32'h0000_2000;
        n = 0;
        while (!t4_done && n < 60) begin step(); n++; end
        check_eq("t4_done", {31'b0, t4_done}, 1);
        force_mode = 0;

        // Random traffic.
        phase = 5; p_gnt = 70; p_ready = 70; p_redir = 5; lat_min = 1; lat_max = 3;
        repeat (1500) step();

        // Reset pulse while a request is in flight; its late answer must be ignored.
        phase = 6; p_redir = 0; p_gnt = 100; lat_min = 3; lat_max = 3;
        n = 0;
        while (!(pend && pend_cnt >= 1) && n < 40) begin step(); n++; end
        check_eq("t6_found_outstanding", {31'b0, pend && pend_cnt >= 1}, 1);
        #2;
        imem_rvalid = 0; imem_gnt = 0; redirect_valid = 0; rvalid2 = 0;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_req", imem_req, 1'b0);
        check_eq("t6_rst_valid", if_valid, 1'b0);
        check_eq("t6_rst_instrn", if_instrn, NOP);
        check_eq("t6_rst_pc", if_pc, RPC);
        check_eq("t6_rst_pcp4", if_pcp4, RPC + 32'd4);
        model_reset();
        if (pend) begin orphan = 1; pend_stale = 1; end
        pend2 = 0;
        @(posedge clk);
        if (pend) pend_cnt--;
        @(negedge clk);
        rst_n = 1'b1;
        t6_armed = 1;
        p_ready = 80; lat_min = 1; lat_max = 2;
        repeat (40) step();
        check_eq("t6_restarted", {31'b0, t6_armed}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
